// File: rtl/add64_check_pkg.sv
// Shared types for the 64-bit adder result checker.
// Holds the run-control state encoding and the result width.
// No logic; imported by the checker top and its compare stage.
package add64_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int OPD_W = 64;
    localparam int RES_W = OPD_W + 1;

endpackage

// File: rtl/add64_ref_compare.sv
// Reference expected-sum and equality check for one adder vector.
// Latency: purely combinational.
// Backpressure: none; evaluates whatever operands it is given.
module add64_ref_compare
    import add64_check_pkg::*;
(
    input  logic [OPD_W-1:0] a,
    input  logic [OPD_W-1:0] b,
    input  logic             c_in,
    input  logic [OPD_W-1:0] sum,
    input  logic             c_out,
    output logic             mismatch
);

    logic [RES_W-1:0] expected;

    // Zero-extended behavioural add; bit 64 is the reference carry-out.
    always_comb begin
        expected = {1'b0, a} + {1'b0, b} + {{(RES_W-1){1'b0}}, c_in};
        mismatch = (expected != {c_out, sum});
    end

endmodule

// File: rtl/add64_result_checker.sv
// Checks a stream of 64-bit adder results against a reference sum.
// Latency: counters reflect a vector after the 3rd rising edge counting the accepting edge.
// Backpressure: none; accepts one vector per cycle while running, never stalls.
module add64_result_checker
    import add64_check_pkg::*;
#(
    parameter bit STOP_ON_FAIL = 1'b0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [63:0]      a,
    input  logic [63:0]      b,
    input  logic             c_in,
    input  logic [63:0]      sum,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             error_flag,
    output logic [15:0]      err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [RES_W-1:0] first_fail_sum
);

    state_t state, state_nxt;

    // Stage 1: captured vector
    logic             s1_vld;
    logic [63:0]      s1_a, s1_b, s1_sum;
    logic             s1_cin, s1_cout;
    // Stage 2: compare result
    logic             s2_vld;
    logic             s2_mis;
    logic [RES_W-1:0] s2_obs;
    logic             cmp_mis;

    logic accept;
    logic enter_run;
    logic fail_stop;

    // The stop cycle itself never accepts a vector.
    assign accept    = in_valid && (state == ST_RUN) && !stop;
    assign enter_run = start && ((state == ST_IDLE) || (state == ST_DONE));
    // Registered stage-2 mismatch; lets the vector arriving that cycle still in.
    assign fail_stop = STOP_ON_FAIL && s2_vld && s2_mis;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; start wins over stop outside RUN since stop is ignored there.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)                state_nxt = ST_RUN;
            ST_RUN:   if (stop || fail_stop)    state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s1_vld && !s2_vld)   state_nxt = ST_DONE;
            ST_DONE:  if (start)                state_nxt = ST_RUN;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state and the error counter.
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == 16'd0);
    end

    // Stage 1 capture of the incoming vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_sum  <= '0;
            s1_cin  <= 1'b0;
            s1_cout <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_sum  <= sum;
                s1_cin  <= c_in;
                s1_cout <= c_out;
            end
        end
    end

    add64_ref_compare u_cmp (
        .a        (s1_a),
        .b        (s1_b),
        .c_in     (s1_cin),
        .sum      (s1_sum),
        .c_out    (s1_cout),
        .mismatch (cmp_mis)
    );

    // Stage 2 registers the compare verdict and the observed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_mis <= 1'b0;
            s2_obs <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_mis <= cmp_mis;
                s2_obs <= {s1_cout, s1_sum};
            end
        end
    end

    // Stage 3 counters; cleared on entry to RUN, saturating, first failure latched once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_flag     <= 1'b0;
            err_count      <= '0;
            vec_count      <= '0;
            first_fail_idx <= '0;
            first_fail_sum <= '0;
        end else if (enter_run) begin
            error_flag     <= 1'b0;
            err_count      <= '0;
            vec_count      <= '0;
            first_fail_idx <= '0;
            first_fail_sum <= '0;
        end else if (s2_vld) begin
            if (!(&vec_count)) vec_count <= vec_count + 1'b1;
            if (s2_mis) begin
                if (!(&err_count)) err_count <= err_count + 1'b1;
                if (!error_flag) begin
                    error_flag     <= 1'b1;
                    first_fail_idx <= vec_count;
                    first_fail_sum <= s2_obs;
                end
            end
        end
    end

endmodule

// File: tb/tb_add64_result_checker.sv
// Self-checking bench for add64_result_checker.
// Two instances share stimulus: free-running (32-bit counts) and stop-on-fail (4-bit counts).
// Expected results come from a vector-level model of the checking rules.
module tb_add64_result_checker;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, in_valid, c_in, c_out;
    logic [63:0] a, b, sum;

    logic        busy0, done0, pass0, eflag0;
    logic [15:0] errc0;
    logic [31:0] vecc0, fidx0;
    logic [64:0] fsum0;
    logic        busy1, done1, pass1, eflag1;
    logic [15:0] errc1;
    logic [3:0]  vecc1, fidx1;
    logic [64:0] fsum1;

    int n_total = 0;
    int n_bad   = 0;

    // Model of the current run on instance 0
    int          m_vec, m_err, m_first_idx;
    logic [64:0] m_first_sum;
    bit          m_flag;

    add64_result_checker #(.STOP_ON_FAIL(1'b0), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
        .busy(busy0), .done(done0), .pass(pass0), .error_flag(eflag0),
        .err_count(errc0), .vec_count(vecc0), .first_fail_idx(fidx0), .first_fail_sum(fsum0)
    );

    add64_result_checker #(.STOP_ON_FAIL(1'b1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
        .busy(busy1), .done(done1), .pass(pass1), .error_flag(eflag1),
        .err_count(errc1), .vec_count(vecc1), .first_fail_idx(fidx1), .first_fail_sum(fsum1)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] good_sum(input logic [63:0] va, input logic [63:0] vb,
                                             input logic vcin);
        logic [64:0] r;
        r = {1'b0, va} + {1'b0, vb};
        r = r + (vcin ? 65'd1 : 65'd0);
        return r;
    endfunction

    task automatic model_clear();
        m_vec = 0; m_err = 0; m_first_idx = 0; m_first_sum = '0; m_flag = 0;
    endtask

    task automatic model_accept(input logic [63:0] va, input logic [63:0] vb,
                                input logic vcin, input logic [64:0] obs);
        if (good_sum(va, vb, vcin) != obs) begin
            m_err++;
            if (!m_flag) begin
                m_flag      = 1;
                m_first_idx = m_vec;
                m_first_sum = obs;
            end
        end
        m_vec++;
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic send(input logic [63:0] va, input logic [63:0] vb, input logic vcin,
                        input logic [64:0] obs, input logic vv);
        a = va; b = vb; c_in = vcin; sum = obs[63:0]; c_out = obs[64]; in_valid = vv;
        @(negedge clk);
        if (vv) model_accept(va, vb, vcin, obs);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic pulse_stop();
        in_valid = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int budget);
        int n;
        n = 0;
        while (((sel == 0) ? done0 : done1) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_val((sel == 0) ? "done0_wait" : "done1_wait",
                (sel == 0) ? done0 : done1, 1'b1);
    endtask

    task automatic check_run0(input string tag);
        chk_val({tag, "_done"},  done0, 1'b1);
        chk_val({tag, "_busy"},  busy0, 1'b0);
        chk_val({tag, "_pass"},  pass0, (m_err == 0));
        chk_val({tag, "_vec"},   vecc0, m_vec);
        chk_val({tag, "_err"},   errc0, m_err);
        chk_val({tag, "_flag"},  eflag0, m_flag);
        if (m_flag) begin
            chk_val({tag, "_fidx"}, fidx0, m_first_idx);
            chk_val({tag, "_fsum"}, fsum0, m_first_sum);
        end
    endtask

    initial begin
        logic [63:0] va, vb;
        logic        vcin;
        logic [64:0] obs;
        int          p;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sum = '0; c_out = 1'b0;
        model_clear();

        // Reset state
        #3;
        chk_val("rst_busy", busy0, 1'b0);
        chk_val("rst_done", done0, 1'b0);
        chk_val("rst_pass", pass0, 1'b0);
        chk_val("rst_flag", eflag0, 1'b0);
        chk_val("rst_err",  errc0, 0);
        chk_val("rst_vec",  vecc0, 0);
        chk_val("rst_fidx", fidx0, 0);
        chk_val("rst_fsum", fsum0, 0);
        chk_val("rst_busy1", busy1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("idle_busy", busy0, 1'b0);

        // 100 correct vectors a=b=i
        pulse_start();
        chk_val("run_busy", busy0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            va = 64'(i);
            vcin = i[0];
            send(va, va, vcin, good_sum(va, va, vcin), 1'b1);
        end
        pulse_stop();
        wait_done(0, 20);
        check_run0("seq100");

        // Vector 5 with sum bit 0 flipped
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            va = 64'(i * 3 + 7);
            vb = 64'(i * 11);
            obs = good_sum(va, vb, 1'b0);
            if (i == 5) obs = obs ^ 65'd1;
            send(va, vb, 1'b0, obs, 1'b1);
        end
        pulse_stop();
        wait_done(0, 20);
        check_run0("bad5");
        chk_val("bad5_fidx_abs", fidx0, 5);

        // Carry-out wrap: all-ones + 0 + 1 = {1, 0}
        pulse_start();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0}, 1'b1);
        pulse_stop();
        wait_done(0, 20);
        check_run0("wrap");

        // Randomised vectors with gaps and injected faults
        pulse_start();
        for (int k = 0; k < 300; k++) begin
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) va = '1;
            vcin = 1'($urandom_range(0, 1));
            obs = good_sum(va, vb, vcin);
            if ($urandom_range(0, 9) == 0) begin
                p = $urandom_range(0, 64);
                obs = obs ^ (65'd1 << p);
            end
            send(va, vb, vcin, obs, ($urandom_range(0, 3) != 0));
        end
        pulse_stop();
        wait_done(0, 20);
        check_run0("rand");

        // Stop-on-fail: mismatch at vector 3, in_valid held high
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            va = 64'(i + 100);
            obs = good_sum(va, va, 1'b1);
            if (i == 3) obs = obs ^ (65'd1 << 64);
            send(va, va, 1'b1, obs, 1'b1);
        end
        pulse_stop();
        wait_done(1, 20);
        chk_val("sof_vec",  vecc1, 4'(3 + 3));
        chk_val("sof_err",  errc1, 1);
        chk_val("sof_flag", eflag1, 1'b1);
        chk_val("sof_fidx", fidx1, 3);
        chk_val("sof_pass", pass1, 1'b0);
        wait_done(0, 20);
        check_run0("sof_free");

        // Saturation of the 4-bit vector counter
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            va = {$urandom, $urandom};
            send(va, ~va, 1'b0, good_sum(va, ~va, 1'b0), 1'b1);
        end
        pulse_stop();
        wait_done(1, 20);
        chk_val("sat_vec1",  vecc1, (m_vec > 15) ? 15 : m_vec);
        chk_val("sat_pass1", pass1, 1'b1);
        wait_done(0, 20);
        check_run0("sat_free");

        // stop together with in_valid, then start while draining
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            va = 64'(i + 1);
            send(va, va, 1'b0, good_sum(va, va, 1'b0), 1'b1);
        end
        a = 64'd9; b = 64'd9; sum = 64'd0; c_out = 1'b0; in_valid = 1'b1; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; in_valid = 1'b0; start = 1'b1;
        chk_val("drain_busy", busy0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk_val("drain_done_e1", done0, 1'b0);
        @(negedge clk);
        chk_val("drain_done_e2", done0, 1'b1);
        check_run0("drain");

        // Asynchronous reset with two vectors in flight
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            va = 64'(i * 5);
            send(va, va, 1'b1, good_sum(va, va, 1'b1), 1'b1);
        end
        in_valid = 1'b0;
        chk_val("pre_rst_vec", vecc0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("arst_busy", busy0, 1'b0);
        chk_val("arst_vec",  vecc0, 0);
        chk_val("arst_done", done0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_val("post_rst_busy", busy0, 1'b0);
        chk_val("post_rst_done", done0, 1'b0);
        chk_val("post_rst_vec",  vecc0, 0);
        pulse_start();
        pulse_stop();
        wait_done(0, 20);
        check_run0("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
